// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Command-driven controller for a bank of WIDTH JK flip-flops. Each RUN cycle
//   it computes the J/K drive that loads, clears or steps the bank as a
//   modulo-(MAX_COUNT+1) up/down counter. The bank state changes only through
//   the JK cell equation q_next = (J & ~q) | (~K & q).
//
//   Optional feature: define JK_PAUSE_EN to add the 'pause' input, which
//   stalls the RUN state (J=K=0, step counter frozen, no done/wrap).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   pause      (JK_PAUSE_EN only) stall RUN while high
//   cmd_valid  command present
//   cmd_ready  controller idle and able to accept a command
//   cmd_op     00 LOAD, 01 COUNT_UP, 10 COUNT_DN, 11 CLEAR
//   cmd_data   load value (LOAD)
//   cmd_len    number of count steps (COUNT ops)
//   q          JK bank outputs
//   j_out      J drive currently applied to the bank
//   k_out      K drive currently applied to the bank
//   busy       controller not idle
//   done       one-cycle pulse when a command completes
//   wrap       one-cycle pulse coincident with a wrapped q value
module jk_bank_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 9,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef JK_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  state_t           state, state_nx;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] j_c, k_c, t_c, q_nx;
  logic             done_nx, wrap_nx;
  logic             stall;

`ifdef JK_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // Next-state, J/K drive and pulse generation
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    wrap_nx  = 1'b0;
    j_c      = '0;
    k_c      = '0;
    t_c      = q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = RUN;
          cnt_nx   = cmd_len;
        end
      end
      RUN: begin
        if (!stall) begin
          case (op_r)
            OP_LOAD: begin
              j_c      = data_r;
              k_c      = ~data_r;
              state_nx = DONE;
              done_nx  = 1'b1;
            end
            OP_CLEAR: begin
              k_c      = '1;
              state_nx = DONE;
              done_nx  = 1'b1;
            end
            default: begin
              if (cnt == '0) begin
                // zero-length count: one idle RUN cycle, bank untouched
                state_nx = DONE;
                done_nx  = 1'b1;
              end else begin
                if (op_r == OP_UP) begin
                  t_c     = (q >= MAX_V) ? WIDTH'(0) : q + WIDTH'(1);
                  wrap_nx = (t_c == WIDTH'(0));
                end else begin
                  t_c     = (q == WIDTH'(0) || q > MAX_V) ? MAX_V : q - WIDTH'(1);
                  wrap_nx = (t_c == MAX_V);
                end
                // toggle encoding: J=K=1 exactly on the bits that must flip
                j_c    = q ^ t_c;
                k_c    = q ^ t_c;
                cnt_nx = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
                end
              end
            end
          endcase
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // JK cell equation for the whole bank
  assign q_nx = (j_c & ~q) | (~k_c & q);

  // State, bank and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= 2'b00;
      data_r <= '0;
      cnt    <= '0;
      q      <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      done  <= done_nx;
      wrap  <= wrap_nx;
      if (state == IDLE && cmd_valid) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
      end
    end
  end

  assign j_out     = j_c;
  assign k_out     = k_c;
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer (default parameters).
module tb_jk_bank_sequencer;

  localparam int MAXC = 9;

  logic       clk;
  logic       reset;
  logic       pause;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] q, j_out, k_out;
  logic       busy, done, wrap;

  int checks   = 0;
  int failures = 0;
  int mq       = 0;

  jk_bank_sequencer dut (
    .clk       (clk),
    .reset     (reset),
`ifdef JK_PAUSE_EN
    .pause     (pause),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] len;
    int         exp_q;
    int         exp_wraps;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // packed view {q,j,k,busy,ready,done,wrap}
  task automatic cyc(input string nm, input int eq, input logic [3:0] ej, input logic [3:0] ek,
                     input bit eb, input bit ed, input bit ew);
    chk(nm, 32'({q, j_out, k_out, busy, cmd_ready, done, wrap}),
        32'({4'(eq), ej, ek, eb, ~eb, ed, ew}));
  endtask

  function automatic int next_up(input int v);
    if (v > MAXC) return 0;
    return (v + 1) % (MAXC + 1);
  endfunction

  function automatic int next_dn(input int v);
    if (v > MAXC) return MAXC;
    return (v + MAXC) % (MAXC + 1);
  endfunction

  // Issue one command from idle and check every cycle against the model.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input logic [7:0] len,
                         input bit noise, output int wraps_seen);
    int n, qq, t, runs;
    logic [3:0] ej, ek;
    bit ew, ewn;
    wraps_seen = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    qq = mq;
    ew = 1'b0;
    runs = (op == 2'b00 || op == 2'b11 || len == 0) ? 1 : int'(len);
    for (int i = 0; i < runs; i++) begin
      ewn = 1'b0;
      case (op)
        2'b00:   begin t = int'(d); ej = d; ek = ~d; end
        2'b11:   begin t = 0; ej = 4'h0; ek = 4'hF; end
        2'b01:   begin
          t = (len == 0) ? qq : next_up(qq);
          ewn = (len != 0) && (t == 0);
          ej = 4'(qq ^ t); ek = ej;
        end
        default: begin
          t = (len == 0) ? qq : next_dn(qq);
          ewn = (len != 0) && (t == MAXC);
          ej = 4'(qq ^ t); ek = ej;
        end
      endcase
      cyc("run", qq, ej, ek, 1'b1, 1'b0, ew);
      wraps_seen += int'(wrap);
      if (noise) begin
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_len   = 8'($urandom);
      end
      ew = ewn;
      qq = t;
      @(negedge clk);
    end
    cyc("done", qq, 4'h0, 4'h0, 1'b1, 1'b1, ew);
    wraps_seen += int'(wrap);
    if (noise) cmd_valid = 1'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc("idle", qq, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    mq = qq;
  endtask

  vec_t tbl[$];
  int   w;

  initial begin
    reset = 1'b0; pause = 1'b0; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_data = 4'h0; cmd_len = 8'h0;

    tbl.push_back('{2'b00, 4'd7,  8'd0,  7, 0});
    tbl.push_back('{2'b01, 4'd0,  8'd5,  2, 1});
    tbl.push_back('{2'b00, 4'd1,  8'd0,  1, 0});
    tbl.push_back('{2'b10, 4'd0,  8'd3,  8, 1});
    tbl.push_back('{2'b11, 4'd0,  8'd0,  0, 0});
    tbl.push_back('{2'b01, 4'd0,  8'd0,  0, 0});
    tbl.push_back('{2'b00, 4'd15, 8'd0, 15, 0});
    tbl.push_back('{2'b01, 4'd0,  8'd1,  0, 1});
    tbl.push_back('{2'b00, 4'd12, 8'd0, 12, 0});
    tbl.push_back('{2'b10, 4'd0,  8'd1,  9, 1});
    tbl.push_back('{2'b01, 4'd0,  8'd25, 4, 3});
    tbl.push_back('{2'b10, 4'd0,  8'd12, 2, 1});
    tbl.push_back('{2'b00, 4'd10, 8'd0, 10, 0});
    tbl.push_back('{2'b10, 4'd0,  8'd2,  8, 1});

    // power-on reset
    #2 reset = 1'b1;
    #1 cyc("por", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #9 reset = 1'b0;
    @(negedge clk);

    // busy-ignore and mid-run asynchronous reset
    run_cmd(2'b00, 4'd3, 8'd0, 1'b0, w);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 8'd20;
    @(negedge clk);                        // RUN, q=3
    cmd_valid = 1'b0;
    @(negedge clk);                        // q=4
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'd9;
    @(negedge clk);                        // q=5
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_ignore_q", 32'(q), 32'd6);
    chk("busy_ignore_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("four_steps_q", 32'(q), 32'd7);
    #3 reset = 1'b1;
    #1 cyc("midrun_reset", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #9 reset = 1'b0;
    mq = 0;
    repeat (3) @(negedge clk);
    cyc("after_reset", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].len, 1'b0, w);
      chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].exp_q));
      chk($sformatf("tbl%0d_wraps", i), 32'(w), 32'(tbl[i].exp_wraps));
    end

`ifdef JK_PAUSE_EN
    // pause during a short up-count
    run_cmd(2'b11, 4'd0, 8'd0, 1'b0, w);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc("pz_run0", 0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    pause = 1'b1;
    cyc("pz_step1", 1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cyc("pz_hold1", 1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cyc("pz_hold2", 1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    @(negedge clk);
    cyc("pz_step2", 2, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cyc("pz_done", 3, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    cyc("pz_idle", 3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    mq = 3;
`endif

    // randomized commands against the model, with ignored cmd_valid noise while busy
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom), 4'($urandom), 8'($urandom_range(0, 12)), 1'b1, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
